// File: rtl/dijkstra_weights_ram_pkg.sv
// Shared types and sizing for the Dijkstra weights RAM.
// Holds matrix dimensions, the weight/row types and the store's FSM states.
package dijkstra_pkg;

    localparam int MAX_VIRTEX_NUM   = 16;
    localparam int VIRTEX_DWIDTH    = 32;
    localparam int VIRTEX_AWIDTH    = $clog2(MAX_VIRTEX_NUM);
    localparam int VIRTEX_NUM_WIDTH = $clog2(MAX_VIRTEX_NUM + 1);

    typedef logic [VIRTEX_DWIDTH-1:0] weight_t;

    // All-ones marks "no edge" (infinite distance)
    localparam weight_t WEIGHT_INF = '1;

    typedef weight_t [MAX_VIRTEX_NUM-1:0] weight_row_t;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        MIRROR = 2'd2
    } wram_state_t;

endpackage

// File: rtl/dijkstra_weights_ram.sv
// Row-wide adjacency-matrix weight store for the Dijkstra core.
// Reads return a whole row one cycle after the strobe; a host loader writes
// single cells over a valid/ready port; an init sweep fills every cell with
// infinity one row per cycle.
// Optional build macro WEIGHTS_RAM_UNDIRECTED_EN: each off-diagonal write is
// mirrored to the transposed cell in a following MIRROR cycle.
module dijkstra_weights_ram
    import dijkstra_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     weights_ram_cs_i,
    input  logic [VIRTEX_AWIDTH-1:0] weights_ram_addr_i,
    output weight_row_t              weights_ram_data_o,
    output logic                     weights_ram_rvalid_o,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [VIRTEX_AWIDTH-1:0] wr_row_i,
    input  logic [VIRTEX_AWIDTH-1:0] wr_col_i,
    input  weight_t                  wr_data_i,
    input  logic                     init_start_i,
    output logic                     init_busy_o
);

    wram_state_t              state_q;
    wram_state_t              state_d;
    logic [VIRTEX_AWIDTH-1:0] row_cnt_q;
    logic [VIRTEX_AWIDTH-1:0] row_cnt_d;
    logic                     wr_accept;

    weight_row_t mem [MAX_VIRTEX_NUM];

`ifdef WEIGHTS_RAM_UNDIRECTED_EN
    logic [VIRTEX_AWIDTH-1:0] mir_row_q;
    logic [VIRTEX_AWIDTH-1:0] mir_col_q;
    weight_t                  mir_data_q;
`endif

    assign wr_ready_o  = (state_q == IDLE);
    assign init_busy_o = (state_q == INIT);

    // A clear request wins over a same-cycle write, so that write is dropped
    assign wr_accept = (state_q == IDLE) && wr_valid_i && !init_start_i;

    // State register and sweep row counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= INIT;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    // Next-state logic: sweep rows, accept writes, optionally mirror them
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        case (state_q)
            INIT: begin
                row_cnt_d = row_cnt_q + 1'b1;
                if (row_cnt_q == VIRTEX_AWIDTH'(MAX_VIRTEX_NUM - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (init_start_i) begin
                    state_d   = INIT;
                    row_cnt_d = '0;
                end
`ifdef WEIGHTS_RAM_UNDIRECTED_EN
                else if (wr_accept && (wr_row_i != wr_col_i)) begin
                    state_d = MIRROR;
                end
`endif
            end
            MIRROR: begin
                if (init_start_i) begin
                    state_d   = INIT;
                    row_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = INIT;
                row_cnt_d = '0;
            end
        endcase
    end

`ifdef WEIGHTS_RAM_UNDIRECTED_EN
    // Capture an accepted write so its transpose can be stored next cycle
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mir_row_q  <= wr_row_i;
            mir_col_q  <= wr_col_i;
            mir_data_q <= wr_data_i;
        end
    end
`endif

    // Matrix storage: whole-row clear during the sweep, single-cell host writes
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[row_cnt_q] <= '1;
        end else if (wr_accept) begin
            mem[wr_row_i][wr_col_i] <= wr_data_i;
        end
`ifdef WEIGHTS_RAM_UNDIRECTED_EN
        else if (state_q == MIRROR) begin
            mem[mir_col_q][mir_row_q] <= mir_data_q;
        end
`endif
    end

    // Registered row read; read-first against a same-edge write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weights_ram_data_o   <= '0;
            weights_ram_rvalid_o <= 1'b0;
        end else begin
            weights_ram_rvalid_o <= weights_ram_cs_i;
            if (weights_ram_cs_i) begin
                weights_ram_data_o <= mem[weights_ram_addr_i];
            end
        end
    end

endmodule

// File: tb/tb_dijkstra_weights_ram.sv
// Directed self-checking bench for dijkstra_weights_ram.
// Keeps its own copy of the expected matrix, updated by hand-chosen writes.
module tb_dijkstra_weights_ram;
    import dijkstra_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs;
    logic [3:0]  addr;
    weight_row_t rd_data;
    logic        rvalid;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_row;
    logic [3:0]  wr_col;
    logic [31:0] wr_data;
    logic        init_start;
    logic        init_busy;

    logic [31:0] exp_w [16][16];
    int          num_checks = 0;
    int          num_fail   = 0;

    dijkstra_weights_ram dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .weights_ram_cs_i     (cs),
        .weights_ram_addr_i   (addr),
        .weights_ram_data_o   (rd_data),
        .weights_ram_rvalid_o (rvalid),
        .wr_valid_i           (wr_valid),
        .wr_ready_o           (wr_ready),
        .wr_row_i             (wr_row),
        .wr_col_i             (wr_col),
        .wr_data_i            (wr_data),
        .init_start_i         (init_start),
        .init_busy_o          (init_busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Global watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkRow(input int row, input string tag);
        for (int c = 0; c < 16; c++) begin
            checkOutput($sformatf("%s[%0d][%0d]", tag, row, c), rd_data[c], exp_w[row][c]);
        end
    endtask

    task automatic modelClear();
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                exp_w[r][c] = 32'hFFFF_FFFF;
            end
        end
    endtask

    task automatic readRow(input int row);
        cs   = 1'b1;
        addr = 4'(row);
        tick();
        cs   = 1'b0;
        checkOutput($sformatf("rvalid_row%0d", row), 32'(rvalid), 32'd1);
        checkRow(row, "rd");
    endtask

    task automatic readAll(input string tag);
        for (int r = 0; r < 16; r++) begin
            readRow(r);
        end
        $display("[TB] %s: all rows read", tag);
    endtask

    // One host write; waits (bounded) for ready, then updates the model
    task automatic applyStimulus(input int row, input int col, input logic [31:0] data);
        for (int i = 0; i < 8; i++) begin
            if (wr_ready) break;
            tick();
        end
        checkOutput("wr_ready_pre", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_row   = 4'(row);
        wr_col   = 4'(col);
        wr_data  = data;
        tick();
        wr_valid = 1'b0;
        exp_w[row][col] = data;
`ifdef WEIGHTS_RAM_UNDIRECTED_EN
        exp_w[col][row] = data;
`endif
    endtask

    // Count cycles with init_busy high; optionally poke init_start mid-sweep
    task automatic measureInit(input bit poke);
        int n;
        bit ready_seen;
        n = 0;
        ready_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!init_busy) break;
            n++;
            if (wr_ready) ready_seen = 1'b1;
            if (poke && i == 3) init_start = 1'b1;
            tick();
            init_start = 1'b0;
        end
        checkOutput("init_len", 32'(n), 32'd16);
        checkOutput("ready_in_init", 32'(ready_seen), 32'd0);
        checkOutput("ready_after_init", 32'(wr_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        cs         = 1'b0;
        addr       = '0;
        wr_valid   = 1'b0;
        wr_row     = '0;
        wr_col     = '0;
        wr_data    = '0;
        init_start = 1'b0;
        modelClear();

        // Reset values
        tick();
        tick();
        tick();
        checkOutput("rst_data0", rd_data[0], 32'h0);
        checkOutput("rst_data15", rd_data[15], 32'h0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst_ready", 32'(wr_ready), 32'd0);
        checkOutput("rst_busy", 32'(init_busy), 32'd1);

        // Release reset and time the initial sweep
        rst_n = 1'b1;
        measureInit(1'b0);
        readAll("post-init");

        // Load a small graph and read row 0
        applyStimulus(0, 1, 32'hA);
        applyStimulus(0, 2, 32'h1E);
        applyStimulus(0, 3, 32'h32);
        applyStimulus(0, 4, 32'hA);
        applyStimulus(2, 4, 32'hA);
        applyStimulus(3, 1, 32'h28);
        applyStimulus(3, 2, 32'h14);
        applyStimulus(4, 2, 32'h1E);
        readRow(0);
        checkOutput("row0_c1", rd_data[1], 32'hA);
        checkOutput("row0_c3", rd_data[3], 32'h32);

        // Back-to-back reads of rows 3, 4, 2
        cs   = 1'b1;
        addr = 4'd3;
        tick();
        addr = 4'd4;
        checkOutput("b2b_rvalid3", 32'(rvalid), 32'd1);
        checkRow(3, "b2b");
        tick();
        addr = 4'd2;
        checkOutput("b2b_rvalid4", 32'(rvalid), 32'd1);
        checkRow(4, "b2b");
        tick();
        cs = 1'b0;
        checkOutput("b2b_rvalid2", 32'(rvalid), 32'd1);
        checkRow(2, "b2b");
        tick();
        checkOutput("hold_rvalid", 32'(rvalid), 32'd0);
        checkRow(2, "hold");

        // Read/write collision on row 3: read-first
        wr_valid = 1'b1;
        wr_row   = 4'd3;
        wr_col   = 4'd5;
        wr_data  = 32'h7;
        cs       = 1'b1;
        addr     = 4'd3;
        tick();
        wr_valid = 1'b0;
        cs       = 1'b0;
        checkOutput("coll_rvalid", 32'(rvalid), 32'd1);
        checkOutput("coll_old_c5", rd_data[5], 32'hFFFF_FFFF);
        checkRow(3, "coll_old");
        exp_w[3][5] = 32'h7;
`ifdef WEIGHTS_RAM_UNDIRECTED_EN
        exp_w[5][3] = 32'h7;
`endif
        tick();
        readRow(3);
        checkOutput("coll_new_c5", rd_data[5], 32'h7);

        // Clear request with a same-cycle write: write must be dropped
        init_start = 1'b1;
        wr_valid   = 1'b1;
        wr_row     = 4'd3;
        wr_col     = 4'd7;
        wr_data    = 32'h55;
        tick();
        init_start = 1'b0;
        wr_valid   = 1'b0;
        checkOutput("clr_busy", 32'(init_busy), 32'd1);
        checkOutput("clr_ready", 32'(wr_ready), 32'd0);
        // Row 3 is not yet cleared on the first sweep cycle
        readRow(3);
        checkOutput("clr_drop_c7", rd_data[7], 32'hFFFF_FFFF);
        checkOutput("clr_partial_c1", rd_data[1], 32'h28);
        tick();
        tick();
        tick();
        tick();

        // Reset 5 cycles into the sweep, sweep must restart in full
        rst_n = 1'b0;
        tick();
        checkOutput("midrst_busy", 32'(init_busy), 32'd1);
        checkOutput("midrst_ready", 32'(wr_ready), 32'd0);
        checkOutput("midrst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("midrst_data1", rd_data[1], 32'h0);
        rst_n = 1'b1;
        measureInit(1'b1);
        modelClear();
        readAll("post-restart");

        // Off-diagonal then diagonal write
        checkOutput("dir_ready_pre", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_row   = 4'd1;
        wr_col   = 4'd6;
        wr_data  = 32'h5;
        tick();
        wr_valid = 1'b0;
        exp_w[1][6] = 32'h5;
`ifdef WEIGHTS_RAM_UNDIRECTED_EN
        exp_w[6][1] = 32'h5;
        checkOutput("mirror_ready", 32'(wr_ready), 32'd0);
        tick();
        checkOutput("mirror_done_ready", 32'(wr_ready), 32'd1);
        readRow(6);
        checkOutput("mirror_c1", rd_data[1], 32'h5);
`else
        checkOutput("directed_ready", 32'(wr_ready), 32'd1);
        readRow(6);
        checkOutput("directed_c1", rd_data[1], 32'hFFFF_FFFF);
`endif
        readRow(1);
        checkOutput("row1_c6", rd_data[6], 32'h5);

        wr_valid = 1'b1;
        wr_row   = 4'd2;
        wr_col   = 4'd2;
        wr_data  = 32'h9;
        tick();
        wr_valid = 1'b0;
        exp_w[2][2] = 32'h9;
        checkOutput("diag_ready", 32'(wr_ready), 32'd1);
        readRow(2);
        checkOutput("diag_c2", rd_data[2], 32'h9);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
